bit_serial_alu_ctrl: RTL

Bit-serial ALU sequencer: accepts a WIDTH-bit operation over a valid/ready handshake, then drives a single 1-bit ALU slice once per clock, LSB first. It holds the ripple carry between cycles and assembles the result word, so one slice computes AND, OR, ADD, SUB, XOR, SLT and NOR for any WIDTH. It sits between the issue logic and the writeback register, trading latency for area in the small-core datapath.

---
 rtl/bit_serial_alu_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: LSB-first 1-bit ALU slice sequencer (in: in_valid/in_ready, op, a, b; out: out_valid/out_ready, result, cout, zero; ovf port when BSALU_OVERFLOW_EN is defined)
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef BSALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_XOR = 4'b0100, OP_SLT = 4'b0111, OP_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, shifted, final_res;
  logic [3:0] op_r;
  logic [CW-1:0] cnt;
  logic carry, last, is_sub, is_arith, ai, bi, sum, co, bit_out;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = state == RUN && cnt == CW'(WIDTH - 1);
  assign is_sub    = op_r == OP_SUB || op_r == OP_SLT;
  assign is_arith  = op_r == OP_ADD || op_r == OP_SUB;
  assign ai        = a_sr[0];
  assign bi        = b_sr[0] ^ is_sub;
  assign sum       = ai ^ bi ^ carry;
  assign co        = (ai & bi) | (carry & (ai ^ bi));
  always_comb begin
    bit_out = op_r == OP_AND ? ai & b_sr[0] :
              op_r == OP_OR  ? ai | b_sr[0] :
              op_r == OP_XOR ? ai ^ b_sr[0] :
              op_r == OP_NOR ? ~(ai | b_sr[0]) :
              (is_arith || op_r == OP_SLT) ? sum : 1'b0;
    shifted   = {bit_out, result[WIDTH-1:1]};
    // SLT: signed less-than is the sign of a-b corrected by its overflow
    final_res = op_r == OP_SLT ? {{(WIDTH-1){1'b0}}, sum ^ carry ^ co} : shifted;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      op_r   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b1;
`ifdef BSALU_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_sr  <= a;
      b_sr  <= b;
      op_r  <= op;
      cnt   <= '0;
      carry <= op == OP_SUB || op == OP_SLT;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= co;
      cnt    <= last ? cnt : cnt + CW'(1);
      result <= last ? final_res : shifted;
      if (last) begin
        cout <= is_arith & co;
        zero <= final_res == '0;
`ifdef BSALU_OVERFLOW_EN
        ovf  <= is_arith & (carry ^ co);
`endif
      end
    end
  end
endmodule
